cache_controller: RTL

//  CPU-side initiator for the 64-block x 4-word main memory: a direct-mapped,

---
 rtl/cache_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/cache_controller.sv
// Direct-mapped, write-back, write-allocate data cache sitting between the
// pipeline MEM stage and the 64-block x 4-word main memory.
module cache_controller #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned MEM_LAT   = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         mem_rw,
    output logic [9:0]   mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata
);

    localparam int unsigned IB = $clog2(NUM_LINES);
    localparam int unsigned TW = 6 - IB;
    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        ALLOCATE  = 2'd3
    } cacheState_t;

    cacheState_t state;
    cacheState_t nextState;

    logic [CW-1:0]  latCnt;
    logic [CW-1:0]  latCntNext;

    // Request captured at acceptance so later input changes cannot disturb it
    logic [9:2]     reqAddr;
    logic           reqWe;
    logic [31:0]    reqWdata;

    logic [NUM_LINES-1:0] validQ;
    logic [NUM_LINES-1:0] dirtyQ;
    logic [TW-1:0]        tagQ  [NUM_LINES];
    logic [127:0]         dataQ [NUM_LINES];

    logic           readyNext;
    logic [31:0]    rdataNext;
    logic           memRwNext;
    logic [9:0]     memAddrNext;
    logic [127:0]   memWdataNext;
    logic           fillEn;
    logic           storeEn;

    logic [TW-1:0]  reqTag;
    logic [IB-1:0]  reqIdx;
    logic [1:0]     reqWord;
    logic           lineHit;
    logic           victimDirty;
    logic           xferDone;

    // Byte offset is meaningless for word-aligned accesses
    logic           unusedAddrBits;
    assign unusedAddrBits = ^cpu_addr[1:0];

    assign reqTag      = reqAddr[9:4+IB];
    assign reqIdx      = reqAddr[4+IB-1:4];
    assign reqWord     = reqAddr[3:2];
    assign lineHit     = validQ[reqIdx] && (tagQ[reqIdx] == reqTag);
    assign victimDirty = validQ[reqIdx] && dirtyQ[reqIdx];
    assign xferDone    = (latCnt == CW'(MEM_LAT - 1));

    // Control state, request capture and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            latCnt    <= '0;
            reqAddr   <= '0;
            reqWe     <= 1'b0;
            reqWdata  <= '0;
            validQ    <= '0;
            dirtyQ    <= '0;
            cpu_ready <= 1'b0;
            cpu_rdata <= '0;
            mem_rw    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= nextState;
            latCnt    <= latCntNext;
            cpu_ready <= readyNext;
            cpu_rdata <= rdataNext;
            mem_rw    <= memRwNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            if (state == IDLE && cpu_req) begin
                reqAddr  <= cpu_addr[9:2];
                reqWe    <= cpu_we;
                reqWdata <= cpu_wdata;
            end
            if (fillEn) begin
                validQ[reqIdx] <= 1'b1;
                dirtyQ[reqIdx] <= 1'b0;
            end else if (storeEn) begin
                dirtyQ[reqIdx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays; contents are qualified by validQ so need no reset
    always_ff @(posedge clk) begin
        if (fillEn) begin
            dataQ[reqIdx] <= mem_rdata;
            tagQ[reqIdx]  <= reqTag;
        end else if (storeEn) begin
            dataQ[reqIdx][{reqWord, 5'b0} +: 32] <= reqWdata;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        nextState    = state;
        latCntNext   = latCnt;
        readyNext    = 1'b0;
        rdataNext    = cpu_rdata;
        memRwNext    = 1'b0;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        fillEn       = 1'b0;
        storeEn      = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_req) begin
                    nextState = COMPARE;
                end
            end
            COMPARE: begin
                if (lineHit) begin
                    readyNext = 1'b1;
                    nextState = IDLE;
                    if (reqWe) begin
                        storeEn = 1'b1;
                    end else begin
                        rdataNext = dataQ[reqIdx][{reqWord, 5'b0} +: 32];
                    end
                end else if (victimDirty) begin
                    nextState    = WRITEBACK;
                    latCntNext   = '0;
                    memRwNext    = 1'b1;
                    memAddrNext  = {tagQ[reqIdx], reqIdx, 4'b0};
                    memWdataNext = dataQ[reqIdx];
                end else begin
                    nextState   = ALLOCATE;
                    latCntNext  = '0;
                    memAddrNext = {reqTag, reqIdx, 4'b0};
                end
            end
            WRITEBACK: begin
                if (xferDone) begin
                    nextState   = ALLOCATE;
                    latCntNext  = '0;
                    memAddrNext = {reqTag, reqIdx, 4'b0};
                end else begin
                    memRwNext  = 1'b1;
                    latCntNext = latCnt + CW'(1);
                end
            end
            ALLOCATE: begin
                if (xferDone) begin
                    nextState  = COMPARE;
                    latCntNext = '0;
                    fillEn     = 1'b1;
                end else begin
                    latCntNext = latCnt + CW'(1);
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule
